// File: rtl/pll_reconfig_seq.sv
// Sequencer that replays a small table of register writes into a PLL reconfig
// block over Avalon-MM, then waits (with timeout) for the PLL to relock.
module pll_reconfig_seq #(
  parameter int TBL_DEPTH    = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int SETTLE       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tbl_we,
  input  logic [$clog2(TBL_DEPTH)-1:0] tbl_addr,
  input  logic [37:0]                  tbl_wdata,
  input  logic [$clog2(TBL_DEPTH):0]   tbl_len,
  input  logic                         start,
  output logic [5:0]                   mgmt_address,
  output logic                         mgmt_write,
  output logic [31:0]                  mgmt_writedata,
  input  logic                         mgmt_waitrequest,
  input  logic                         pll_locked,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int AW      = $clog2(TBL_DEPTH);
  localparam int CNT_MAX = (LOCK_TIMEOUT > SETTLE) ? LOCK_TIMEOUT : SETTLE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [AW:0]   DEPTH_L      = (AW+1)'(TBL_DEPTH);
  localparam logic [AW:0]   IDX_ONE      = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MODE,
    S_TABLE,
    S_STARTW,
    S_SETTLE,
    S_WAITLOCK,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mgmt_write_q, mgmt_write_d;
  logic [5:0]    mgmt_address_q, mgmt_address_d;
  logic [31:0]   mgmt_writedata_q, mgmt_writedata_d;
  logic          sync1_q, lock_s_q;
  logic [37:0]   entry;

  logic [37:0]   tbl_mem [TBL_DEPTH];

  // Table is frozen while a sequence runs so the bus data cannot change mid-transfer.
  always_ff @(posedge clk) begin
    if (tbl_we && !busy_q) begin
      tbl_mem[tbl_addr] <= tbl_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      lock_s_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    error_d = error_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = (tbl_len > DEPTH_L) ? DEPTH_L : tbl_len;
          error_d = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_MODE;
        end
      end
      S_MODE: begin
        if (!mgmt_waitrequest) begin
          state_d = (len_q == '0) ? S_STARTW : S_TABLE;
        end
      end
      S_TABLE: begin
        if (!mgmt_waitrequest) begin
          if ((idx_q + IDX_ONE) == len_q) begin
            state_d = S_STARTW;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      S_STARTW: begin
        if (!mgmt_waitrequest) begin
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_WAITLOCK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAITLOCK: begin
        if (lock_s_q) begin
          state_d = S_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the bus is driven straight from flops.
    entry            = tbl_mem[idx_d[AW-1:0]];
    busy_d           = (state_d != S_IDLE);
    done_d           = (state_d == S_DONE);
    mgmt_write_d     = 1'b0;
    mgmt_address_d   = 6'h00;
    mgmt_writedata_d = 32'h0000_0000;

    case (state_d)
      S_MODE: begin
        mgmt_write_d = 1'b1;
      end
      S_TABLE: begin
        mgmt_write_d     = 1'b1;
        mgmt_address_d   = entry[37:32];
        mgmt_writedata_d = entry[31:0];
      end
      S_STARTW: begin
        mgmt_write_d     = 1'b1;
        mgmt_address_d   = 6'h02;
        mgmt_writedata_d = 32'h0000_0001;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      len_q            <= '0;
      idx_q            <= '0;
      cnt_q            <= '0;
      error_q          <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      mgmt_write_q     <= 1'b0;
      mgmt_address_q   <= 6'h00;
      mgmt_writedata_q <= 32'h0000_0000;
    end else begin
      state_q          <= state_d;
      len_q            <= len_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      error_q          <= error_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      mgmt_write_q     <= mgmt_write_d;
      mgmt_address_q   <= mgmt_address_d;
      mgmt_writedata_q <= mgmt_writedata_d;
    end
  end

  assign mgmt_write     = mgmt_write_q;
  assign mgmt_address   = mgmt_address_q;
  assign mgmt_writedata = mgmt_writedata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: an Avalon-MM responder logs every completed
// write and the main thread compares the log against hand-written expectations.
module tb_pll_reconfig_seq;

  localparam int TBL_DEPTH    = 8;
  localparam int LOCK_TIMEOUT = 40;
  localparam int SETTLE       = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tbl_we;
  logic [2:0]  tbl_addr;
  logic [37:0] tbl_wdata;
  logic [3:0]  tbl_len;
  logic        start;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;
  logic        pll_locked;
  logic        busy;
  logic        done;
  logic        error;

  pll_reconfig_seq #(
    .TBL_DEPTH    (TBL_DEPTH),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .SETTLE       (SETTLE)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tbl_we           (tbl_we),
    .tbl_addr         (tbl_addr),
    .tbl_wdata        (tbl_wdata),
    .tbl_len          (tbl_len),
    .start            (start),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_waitrequest (mgmt_waitrequest),
    .pll_locked       (pll_locked),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nChecks = 0;
  int nPass   = 0;

  int waitN    = 0;
  int waitCnt  = 0;
  int stabErr  = 0;
  int doneCnt  = 0;
  int doneCyc  = 0;
  int startCyc = 0;

  logic [5:0]  holdAddr;
  logic [31:0] holdData;
  logic [5:0]  xferAddr[$];
  logic [31:0] xferData[$];
  int          xferCyc[$];
  int          xferHold[$];
  logic [5:0]  expAddr[$];
  logic [31:0] expData[$];

  // Responder: stalls each write for waitN cycles, logs the completing cycle and
  // counts any address/data change while the write is stalled.
  initial begin
    mgmt_waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      if (mgmt_write === 1'b1) begin
        if (waitCnt == 0) begin
          holdAddr = mgmt_address;
          holdData = mgmt_writedata;
        end else if (mgmt_address !== holdAddr || mgmt_writedata !== holdData) begin
          stabErr++;
        end
        if (waitCnt < waitN) begin
          mgmt_waitrequest = 1'b1;
          waitCnt++;
        end else begin
          mgmt_waitrequest = 1'b0;
          xferAddr.push_back(mgmt_address);
          xferData.push_back(mgmt_writedata);
          xferCyc.push_back(cyc);
          xferHold.push_back(waitCnt + 1);
          waitCnt = 0;
        end
      end else begin
        mgmt_waitrequest = 1'b0;
        waitCnt = 0;
      end
      if (done === 1'b1) begin
        doneCnt++;
        doneCyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] len);
    @(negedge clk);
    tbl_len = len;
    start   = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    startCyc = cyc;
  endtask

  task automatic writeEntry(input logic [2:0] idx, input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    tbl_we    = 1'b1;
    tbl_addr  = idx;
    tbl_wdata = {a, d};
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic clearLog();
    xferAddr.delete();
    xferData.delete();
    xferCyc.delete();
    xferHold.delete();
    expAddr.delete();
    expData.delete();
    doneCnt = 0;
    stabErr = 0;
  endtask

  task automatic expectWrite(input logic [5:0] a, input logic [31:0] d);
    expAddr.push_back(a);
    expData.push_back(d);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, busy, 1'b0);
  endtask

  task automatic checkXfers(input string tag);
    checkOutput({tag, "_count"}, xferAddr.size(), expAddr.size());
    for (int i = 0; i < expAddr.size() && i < xferAddr.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), xferAddr[i], expAddr[i]);
      checkOutput($sformatf("%s_data%0d", tag, i), xferData[i], expData[i]);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    tbl_we     = 1'b0;
    tbl_addr   = '0;
    tbl_wdata  = '0;
    tbl_len    = '0;
    start      = 1'b0;
    pll_locked = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_write", mgmt_write, 1'b0);
    checkOutput("rst_addr", mgmt_address, 6'h00);
    checkOutput("rst_data", mgmt_writedata, 32'h0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_error", error, 1'b0);
    rst_n = 1'b1;

    // Two-entry table, no stalls, lock arrives ~30 cycles after start
    writeEntry(3'd0, 6'h04, 32'h0001_0101);
    writeEntry(3'd1, 6'h05, 32'h0000_0404);
    clearLog();
    expectWrite(6'h00, 32'h0000_0000);
    expectWrite(6'h04, 32'h0001_0101);
    expectWrite(6'h05, 32'h0000_0404);
    expectWrite(6'h02, 32'h0000_0001);
    applyStimulus(4'd2);
    checkOutput("t1_busy", busy, 1'b1);
    repeat (29) @(negedge clk);
    checkOutput("t1_wait_busy", busy, 1'b1);
    pll_locked = 1'b1;
    waitIdle("t1_end", 200);
    checkXfers("t1");
    for (int i = 0; i < 4 && i < xferCyc.size(); i++)
      checkOutput($sformatf("t1_cycle%0d", i), xferCyc[i] - startCyc, i);
    checkOutput("t1_done_cnt", doneCnt, 1);
    checkOutput("t1_error", error, 1'b0);

    // Five-cycle stall on every write
    clearLog();
    waitN = 5;
    expectWrite(6'h00, 32'h0000_0000);
    expectWrite(6'h04, 32'h0001_0101);
    expectWrite(6'h05, 32'h0000_0404);
    expectWrite(6'h02, 32'h0000_0001);
    applyStimulus(4'd2);
    waitIdle("t2_end", 300);
    checkXfers("t2");
    for (int i = 0; i < xferHold.size(); i++)
      checkOutput($sformatf("t2_hold%0d", i), xferHold[i], 6);
    checkOutput("t2_stable", stabErr, 0);
    checkOutput("t2_done_cnt", doneCnt, 1);

    // Lock stuck high: done exactly 2 writes + SETTLE + 1 cycles after start
    clearLog();
    waitN = 0;
    applyStimulus(4'd0);
    waitIdle("t3_end", 100);
    checkOutput("t3_done_delay", doneCyc - startCyc, 7);
    checkOutput("t3_done_cnt", doneCnt, 1);
    checkOutput("t3_error", error, 1'b0);

    // Lock stuck low: timeout after SETTLE + LOCK_TIMEOUT
    clearLog();
    pll_locked = 1'b0;
    applyStimulus(4'd0);
    waitIdle("t4_end", 200);
    checkOutput("t4_done_delay", doneCyc - startCyc, 46);
    checkOutput("t4_done_cnt", doneCnt, 1);
    checkOutput("t4_error", error, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("t4_error_sticky", error, 1'b1);
    pll_locked = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(4'd0);
    checkOutput("t4_error_clear", error, 1'b0);
    checkOutput("t4_restart_busy", busy, 1'b1);
    waitIdle("t4b_end", 100);

    // Empty table, with start and a table write attempted mid-sequence
    clearLog();
    waitN = 3;
    expectWrite(6'h00, 32'h0000_0000);
    expectWrite(6'h02, 32'h0000_0001);
    applyStimulus(4'd0);
    start     = 1'b1;
    tbl_we    = 1'b1;
    tbl_addr  = 3'd0;
    tbl_wdata = {6'h3f, 32'hDEAD_BEEF};
    @(negedge clk);
    start  = 1'b0;
    tbl_we = 1'b0;
    waitIdle("t5_end", 100);
    repeat (3) @(negedge clk);
    checkXfers("t5");
    checkOutput("t5_done_cnt", doneCnt, 1);
    checkOutput("t5_no_restart", busy, 1'b0);
    clearLog();
    waitN = 0;
    expectWrite(6'h00, 32'h0000_0000);
    expectWrite(6'h04, 32'h0001_0101);
    expectWrite(6'h02, 32'h0000_0001);
    applyStimulus(4'd1);
    waitIdle("t5b_end", 100);
    checkXfers("t5b");

    // tbl_len above depth saturates to 8 entries
    for (int i = 2; i < 8; i++)
      writeEntry(3'(i), 6'(8'h10 + i), 32'hA000_0000 + 32'(i));
    clearLog();
    expectWrite(6'h00, 32'h0000_0000);
    expectWrite(6'h04, 32'h0001_0101);
    expectWrite(6'h05, 32'h0000_0404);
    for (int i = 2; i < 8; i++)
      expectWrite(6'(8'h10 + i), 32'hA000_0000 + 32'(i));
    expectWrite(6'h02, 32'h0000_0001);
    applyStimulus(4'd12);
    waitIdle("t6_end", 200);
    checkXfers("t6");

    // Reset asserted while a table write is stalled
    clearLog();
    waitN = 5;
    applyStimulus(4'd2);
    for (int n = 0; n < 100; n++) begin
      if (mgmt_write === 1'b1 && mgmt_address === 6'h04) break;
      @(negedge clk);
    end
    checkOutput("t7_in_table", mgmt_address, 6'h04);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t7_write_drop", mgmt_write, 1'b0);
    checkOutput("t7_busy_drop", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("t7_idle", busy, 1'b0);
    clearLog();
    waitN = 0;
    expectWrite(6'h00, 32'h0000_0000);
    expectWrite(6'h04, 32'h0001_0101);
    expectWrite(6'h05, 32'h0000_0404);
    expectWrite(6'h02, 32'h0000_0001);
    applyStimulus(4'd2);
    waitIdle("t7_end", 100);
    checkXfers("t7");
    checkOutput("t7_done_cnt", doneCnt, 1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
